// File: rtl/imem_loader_pkg.sv
// +--------------------------------------------------------------------------+
// | imem_loader_pkg : shared FSM encoding and sizing for the imem loader     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = 8 * WORD_BYTES;
  // Default instruction-memory size, shared with the memory itself.
  localparam int IMEM_BYTES = 256;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// +--------------------------------------------------------------------------+
// | imem_loader_if : host control, byte stream and memory write port        |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, word_count, in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// +--------------------------------------------------------------------------+
// | imem_loader_byte_packer : little-endian 4-byte word assembly             |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] w_word;

  // Word including the byte being accepted this cycle, so the top can
  // register the complete word on the same edge as the final byte.
  always_comb begin
    w_word                          = r_asm;
    w_word[{r_idx, 3'b000} +: 8]    = i_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= 2'd0;
      r_asm <= '0;
    end else if (i_clear) begin
      r_idx <= 2'd0;
      r_asm <= '0;
    end else if (i_accept) begin
      r_asm <= w_word;
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word       = w_word;
  assign o_word_ready = i_accept && (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +--------------------------------------------------------------------------+
// | imem_loader : byte stream to instruction-memory word writer, core hold   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_loader_if.slave bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_words_left;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_clear;
  logic [31:0]       w_word;
  logic              w_word_ready;
  logic [ADDR_W:0]   w_end_addr;
  logic              w_fits;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_clear    = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // One extra bit so a base near the top of the address space cannot wrap.
  assign w_end_addr = {1'b0, r_cur_addr} + (ADDR_W+1)'(WORD_BYTES);
  assign w_fits     = (w_end_addr <= (ADDR_W+1)'(MEM_BYTES));

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_byte       (bus.in_byte),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_words_left <= '0;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_cur_addr   <= bus.base_addr;
            r_words_left <= bus.word_count;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            if (bus.base_addr[1:0] != 2'b00) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (bus.word_count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_COLLECT;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          // The write strobe is decided here so it is high in the WRITE cycle.
          if (w_word_ready) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b0;
            r_wr_en    <= w_fits;
            if (w_fits) begin
              r_wr_addr <= r_cur_addr;
              r_wr_data <= w_word;
            end
          end
        end

        ST_WRITE: begin
          if (r_wr_en) begin
            r_cur_addr   <= r_cur_addr + ADDR_W'(WORD_BYTES);
            r_words_left <= r_words_left - CNT_W'(1);
            if (r_words_left == CNT_W'(1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_COLLECT;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = r_busy;
  assign bus.cpu_hold = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +--------------------------------------------------------------------------+
// | tb_imem_loader : directed self-checking bench for imem_loader            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   viol = 0;
  logic [127:0] txv;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];

  imem_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(256), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log plus protocol invariants: no byte offered during a write,
  // core held during every write, cpu_hold mirrors busy.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      if (bus.in_ready !== 1'b0 || bus.cpu_hold !== 1'b1) viol = viol + 1;
    end
    if (bus.busy !== bus.cpu_hold) viol = viol + 1;
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int n, input bit gaps);
    int i = first;
    int guard = 0;
    bit tog = 1'b0;
    while (i < first + n && guard < 300) begin
      if (gaps && tog) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = txv[8*i +: 8];
        if (bus.in_ready === 1'b1) i++;
      end
      tog = ~tog;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (i != first + n) begin
      failures++;
      $display("FAIL send_timeout sent=%0d required=%0d", i - first, n);
    end
  endtask

  task automatic wait_done(output int at_cyc);
    int guard = 0;
    while (bus.done !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    at_cyc = cyc;
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout done=%b required=1", bus.done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.wr_en, bus.busy, bus.cpu_hold, bus.done, bus.err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {bus.in_ready, bus.wr_en, bus.busy, bus.cpu_hold, bus.done, bus.err});
    end
    checks++;
    if (bus.wr_addr !== '0 || bus.wr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h data=%h required=0", bus.wr_addr, bus.wr_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input bit gaps);
    int c0, cd;
    wq_addr.delete(); wq_data.delete();
    txv = 128'h0020_0113_0090_0093;
    do_start(64'd0, 16'd2);
    c0 = cyc;
    send_bytes(0, 8, gaps);
    wait_done(cd);
    checks++;
    if (wq_addr.size() != 2) begin
      failures++;
      $display("FAIL b2b_count gaps=%0d got=%0d required=2", gaps, wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 64'd0 || wq_data[0] !== 32'h0090_0093) begin
        failures++;
        $display("FAIL b2b_word0 addr=%h data=%h required 0/00900093", wq_addr[0], wq_data[0]);
      end
      checks++;
      if (wq_addr[1] !== 64'd4 || wq_data[1] !== 32'h0020_0113) begin
        failures++;
        $display("FAIL b2b_word1 addr=%h data=%h required 4/00200113", wq_addr[1], wq_data[1]);
      end
    end
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_status err=%b busy=%b required 0/0", bus.err, bus.busy);
    end
    if (!gaps) begin
      checks++;
      if (cd - c0 != 10) begin
        failures++;
        $display("FAIL b2b_latency got=%0d required=10", cd - c0);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.wr_addr !== 64'd4 || bus.wr_data !== 32'h0020_0113) begin
      failures++;
      $display("FAIL b2b_hold done=%b addr=%h data=%h required 1/4/00200113",
               bus.done, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_overflow();
    int cd;
    wq_addr.delete(); wq_data.delete();
    txv = 128'hCCBB_AA99_8877_6655_4433_2211;
    do_start(64'd248, 16'd3);
    send_bytes(0, 12, 1'b0);
    wait_done(cd);
    checks++;
    if (wq_addr.size() != 2) begin
      failures++;
      $display("FAIL ovf_count got=%0d required=2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 64'd248 || wq_data[0] !== 32'h4433_2211 ||
          wq_addr[1] !== 64'd252 || wq_data[1] !== 32'h8877_6655) begin
        failures++;
        $display("FAIL ovf_words a0=%0d d0=%h a1=%0d d1=%h required 248/44332211 252/88776655",
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.wr_addr !== 64'd252) begin
      failures++;
      $display("FAIL ovf_status err=%b busy=%b addr=%0d required 1/0/252",
               bus.err, bus.busy, bus.wr_addr);
    end
  endtask

  task automatic test_misaligned_and_zero();
    wq_addr.delete(); wq_data.delete();
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h5A;
    do_start(64'd2, 16'd1);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL misalign done=%b err=%b busy=%b rdy=%b required 1/1/0/0",
               bus.done, bus.err, bus.busy, bus.in_ready);
    end
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (wq_addr.size() != 0) begin
      failures++;
      $display("FAIL misalign_write got=%0d required=0", wq_addr.size());
    end
    do_start(64'd0, 16'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_count done=%b err=%b busy=%b required 1/0/0",
               bus.done, bus.err, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int cd;
    wq_addr.delete(); wq_data.delete();
    txv = 128'h0000_0013_0000_BBAA;
    do_start(64'd0, 16'd1);
    send_bytes(0, 2, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid busy=%b rdy=%b done=%b required 0/0/0",
               bus.busy, bus.in_ready, bus.done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(64'd8, 16'd1);
    send_bytes(4, 4, 1'b0);
    wait_done(cd);
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 64'd8 || wq_data[0] !== 32'h0000_0013) begin
      failures++;
      $display("FAIL rst_mid_write n=%0d addr=%0d data=%h required 1/8/00000013",
               wq_addr.size(), wq_addr[0], wq_data[0]);
    end
  endtask

  task automatic test_start_ignored();
    int cd;
    wq_addr.delete(); wq_data.delete();
    txv = 128'h0807_0605_0403_0201;
    do_start(64'd16, 16'd2);
    send_bytes(0, 2, 1'b0);
    do_start(64'd64, 16'd5);
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ign_busy busy=%b hold=%b done=%b required 1/1/0",
               bus.busy, bus.cpu_hold, bus.done);
    end
    send_bytes(2, 6, 1'b0);
    wait_done(cd);
    checks++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 64'd16 || wq_data[0] !== 32'h0403_0201 ||
        wq_addr[1] !== 64'd20 || wq_data[1] !== 32'h0807_0605) begin
      failures++;
      $display("FAIL ign_writes n=%0d a0=%0d d0=%h required 2 writes 16/04030201 20/08070605",
               wq_addr.size(), wq_addr[0], wq_data[0]);
    end
    checks++;
    if (bus.err !== 1'b0 || bus.cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL ign_status err=%b hold=%b required 0/0", bus.err, bus.cpu_hold);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_byte    = 8'h00;
    @(negedge clk);
    test_reset();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_overflow();
    test_misaligned_and_zero();
    test_reset_mid();
    test_start_ignored();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL protocol_invariants got=%0d required=0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
